// File: rtl/product_accumulator_pkg.sv
// Shared encodings and default sizing for the multiply-accumulate consumer.
package product_accumulator_pkg;

   localparam int PW_DEFAULT    = 16;
   localparam int GUARD_DEFAULT = 8;
   localparam int CNT_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      OP_ACC  = 2'b00,
      OP_SUB  = 2'b01,
      OP_LOAD = 2'b10,
      OP_NOP  = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_DRAIN   = 2'b01,
      ST_PRESENT = 2'b10
   } state_t;

endpackage

// File: rtl/product_accumulator_if.sv
// Product input and result output handshake bundle for product_accumulator.
interface product_accumulator_if #(
   parameter int PW    = 16,
   parameter int AW    = 40,
   parameter int CNT_W = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [PW-1:0]    in_plow;
   logic [PW-1:0]    in_phigh;
   logic [1:0]       in_op;
   logic             dump;
   logic             out_valid;
   logic             out_ready;
   logic [AW-1:0]    out_acc;
   logic [CNT_W-1:0] out_count;
   logic             out_ovf;

   modport master (
      output in_valid, in_plow, in_phigh, in_op, dump, out_ready,
      input  in_ready, out_valid, out_acc, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_plow, in_phigh, in_op, dump, out_ready,
      output in_ready, out_valid, out_acc, out_count, out_ovf
   );

endinterface

// File: rtl/product_accumulator_acc_addsub.sv
// Combinational AW-bit ripple adder/subtractor; subtraction inverts b and injects a carry-in.
module acc_addsub #(
   parameter int AW = 40
) (
   input  logic [AW-1:0] i_a,
   input  logic [AW-1:0] i_b,
   input  logic          i_sub,
   output logic [AW-1:0] o_result,
   output logic          o_ovf
);

   logic [AW:0]   w_carry;
   logic [AW-1:0] w_bEff;

   assign w_bEff     = i_b ^ {AW{i_sub}};
   assign w_carry[0] = i_sub;

   // One full-adder stage per bit, carry rippling upward
   for (genvar gi = 0; gi < AW; gi++) begin : g_fullAdder
      assign o_result[gi]  = i_a[gi] ^ w_bEff[gi] ^ w_carry[gi];
      assign w_carry[gi+1] = (i_a[gi] & w_bEff[gi]) |
                             (i_a[gi] & w_carry[gi]) |
                             (w_bEff[gi] & w_carry[gi]);
   end

   // Carry out means wrap when adding; missing carry out means borrow when subtracting
   assign o_ovf = w_carry[AW] ^ i_sub;

endmodule

// File: rtl/product_accumulator.sv
// Registers each product, folds it into a guarded accumulator, and presents/clears on dump.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int PW    = PW_DEFAULT,
   parameter int GUARD = GUARD_DEFAULT,
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input logic                  clk,
   input logic                  rst,
   product_accumulator_if.slave bus
);

   localparam int AW = 2*PW + GUARD;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   logic             r_inReady;
   logic             r_outValid;
   logic             r_s1Valid;
   logic [AW-1:0]    r_s1Prod;
   op_t              r_s1Op;
   logic [AW-1:0]    r_acc;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;

   logic             w_transfer;
   logic [AW-1:0]    w_prodExt;
   logic [AW-1:0]    w_sum;
   logic             w_addOvf;
   logic [CNT_W-1:0] w_countNext;

   assign w_transfer  = bus.in_valid & r_inReady;
   assign w_prodExt   = {{GUARD{1'b0}}, bus.in_phigh, bus.in_plow};
   assign w_countNext = (r_count == CNT_MAX) ? r_count : r_count + CNT_ONE;

   acc_addsub #(.AW(AW)) u_addsub (
      .i_a      (r_acc),
      .i_b      (r_s1Prod),
      .i_sub    (r_s1Op == OP_SUB),
      .o_result (w_sum),
      .o_ovf    (w_addOvf)
   );

   // Stage 1: capture the product and op on every accepted transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1Valid <= 1'b0;
         r_s1Prod  <= '0;
         r_s1Op    <= OP_ACC;
      end else begin
         r_s1Valid <= w_transfer;
         if (w_transfer) begin
            r_s1Prod <= w_prodExt;
            r_s1Op   <= op_t'(bus.in_op);
         end
      end
   end

   // Stage 2 accumulate plus the RUN/DRAIN/PRESENT control; the handshake clear comes last so it wins
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_RUN;
         r_inReady  <= 1'b1;
         r_outValid <= 1'b0;
         r_acc      <= '0;
         r_count    <= '0;
         r_ovf      <= 1'b0;
      end else begin
         if (r_s1Valid) begin
            unique case (r_s1Op)
               OP_ACC, OP_SUB: begin
                  r_acc   <= w_sum;
                  r_ovf   <= r_ovf | w_addOvf;
                  r_count <= w_countNext;
               end
               OP_LOAD: begin
                  r_acc   <= r_s1Prod;
                  r_ovf   <= 1'b0;
                  r_count <= CNT_ONE;
               end
               OP_NOP: begin
                  r_count <= w_countNext;
               end
            endcase
         end

         unique case (r_state)
            ST_RUN: begin
               if (bus.dump) begin
                  r_state   <= ST_DRAIN;
                  r_inReady <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (!r_s1Valid) begin
                  r_state    <= ST_PRESENT;
                  r_outValid <= 1'b1;
               end
            end
            ST_PRESENT: begin
               if (bus.out_ready) begin
                  r_state    <= ST_RUN;
                  r_outValid <= 1'b0;
                  r_inReady  <= 1'b1;
                  r_acc      <= '0;
                  r_count    <= '0;
                  r_ovf      <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_RUN;
               r_inReady  <= 1'b1;
               r_outValid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_inReady;
   assign bus.out_valid = r_outValid;
   assign bus.out_acc   = r_acc;
   assign bus.out_count = r_count;
   assign bus.out_ovf   = r_ovf;

endmodule
